// File: rtl/fc_flatten_classifier.sv
// fc_flatten_classifier: buffers one pooled 4x4x16 int8 image and runs a serial 256x10 FC layer with argmax.
// Ports: clk/rst_n clock and async active-low reset; valid_in/in_data pooled pixel stream (16 ch x 32 bit);
// w_addr/w_q and b_addr/b_q weight and bias ROMs (1-cycle latency); logit_valid/logit_idx/logit per-neuron result;
// class_valid/class_out argmax result; busy while computing; overrun when a pixel arrives outside collection.
module fc_flatten_classifier #(
    parameter int NUM_CH    = 16,
    parameter int NUM_PIX   = 16,
    parameter int NUM_OUT   = 10,
    parameter int ACC_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic [NUM_CH*32-1:0]   in_data,
    output logic [11:0]            w_addr,
    input  logic [7:0]             w_q,
    output logic [3:0]             b_addr,
    input  logic [ACC_WIDTH-1:0]   b_q,
    output logic                   logit_valid,
    output logic [3:0]             logit_idx,
    output logic [ACC_WIDTH-1:0]   logit,
    output logic                   class_valid,
    output logic [3:0]             class_out,
    output logic                   busy,
    output logic                   overrun
);
    localparam int NF = NUM_CH * NUM_PIX;

    typedef enum logic [1:0] {COLLECT, COMPUTE, DONE} state_t;

    state_t                      state_q;
    logic [3:0]                  pix_q, o_q, arg_q;
    logic [8:0]                  k_q;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, max_q;
    logic [7:0]                  feat_q [NF];
    logic [7:0]                  f_idx;
    logic signed [15:0]          prod;
    logic                        last_k;

    // w_q arriving in cycle k belongs to feature k-1; k=256 wraps to 255
    assign f_idx  = k_q[7:0] - 8'd1;
    assign prod   = $signed(feat_q[f_idx]) * $signed(w_q);
    assign acc_d  = ((k_q == 9'd1) ? $signed(b_q) : acc_q) + {{(ACC_WIDTH-16){prod[15]}}, prod};
    assign last_k = (k_q == 9'd256);

    assign w_addr  = (state_q == COMPUTE) ? {o_q, k_q[7:0]} : 12'd0;
    assign b_addr  = (state_q == COMPUTE) ? o_q : 4'd0;
    assign busy    = (state_q == COMPUTE);
    assign overrun = valid_in && (state_q != COLLECT);

    // Channel-major flatten: feature index = channel*NUM_PIX + pixel
    always_ff @(posedge clk) begin
        if (state_q == COLLECT && valid_in)
            for (int c = 0; c < NUM_CH; c++)
                feat_q[c*NUM_PIX + int'(pix_q)] <= in_data[32*c +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            pix_q       <= 4'd0;
            o_q         <= 4'd0;
            k_q         <= 9'd0;
            acc_q       <= '0;
            max_q       <= '0;
            arg_q       <= 4'd0;
            logit_valid <= 1'b0;
            logit_idx   <= 4'd0;
            logit       <= '0;
            class_valid <= 1'b0;
            class_out   <= 4'd0;
        end else begin
            logit_valid <= 1'b0;
            class_valid <= 1'b0;
            case (state_q)
                COLLECT: if (valid_in) begin
                    pix_q <= (pix_q == 4'(NUM_PIX-1)) ? 4'd0 : pix_q + 4'd1;
                    if (pix_q == 4'(NUM_PIX-1)) begin
                        state_q <= COMPUTE;
                        o_q     <= 4'd0;
                        k_q     <= 9'd0;
                    end
                end
                COMPUTE: begin
                    acc_q <= acc_d;
                    k_q   <= last_k ? 9'd0 : k_q + 9'd1;
                    if (last_k) begin
                        logit_valid <= 1'b1;
                        logit       <= acc_d;
                        logit_idx   <= o_q;
                        o_q         <= o_q + 4'd1;
                        // strict compare keeps the lowest index on ties
                        if (o_q == 4'd0 || acc_d > max_q) begin
                            max_q <= acc_d;
                            arg_q <= o_q;
                        end
                        if (o_q == 4'(NUM_OUT-1))
                            state_q <= DONE;
                    end
                end
                DONE: begin
                    class_valid <= 1'b1;
                    class_out   <= arg_q;
                    state_q     <= COLLECT;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_flatten_classifier.sv
// tb_fc_flatten_classifier: scoreboard bench for fc_flatten_classifier with behavioural weight/bias ROMs.
module tb_fc_flatten_classifier;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_in = 1'b0;
    logic [511:0] in_data = '0;
    logic [11:0]  w_addr;
    logic [7:0]   w_q;
    logic [3:0]   b_addr;
    logic [31:0]  b_q;
    logic         logit_valid;
    logic [3:0]   logit_idx;
    logic [31:0]  logit;
    logic         class_valid;
    logic [3:0]   class_out;
    logic         busy;
    logic         overrun;

    fc_flatten_classifier dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .in_data(in_data),
        .w_addr(w_addr), .w_q(w_q), .b_addr(b_addr), .b_q(b_q),
        .logit_valid(logit_valid), .logit_idx(logit_idx), .logit(logit),
        .class_valid(class_valid), .class_out(class_out), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    byte w_rom [2560];
    int  b_rom [10];
    byte feat_m [256];

    always @(posedge clk) begin
        w_q <= w_rom[w_addr];
        b_q <= b_rom[b_addr];
    end

    int checks = 0, errors = 0;
    int cyc = 0, t0 = 0, n_logit = 0, n_class = 0, n_ovr = 0, ix = 0;
    logic busy_p = 1'b0;
    int exp_lg[$], exp_ix[$], exp_cls[$];

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && !busy_p) t0 = cyc;
            busy_p = busy;
            if (overrun) n_ovr++;
            if (logit_valid) begin
                n_logit++;
                if (exp_lg.size() == 0) chk("spurious_logit", 1, 0);
                else begin
                    ix = exp_ix.pop_front();
                    chk("logit", $signed(logit), exp_lg.pop_front());
                    chk("logit_idx", logit_idx, ix);
                    chk("logit_lat", cyc - t0, 257*(ix+1));
                end
            end
            if (class_valid) begin
                n_class++;
                if (exp_cls.size() == 0) chk("spurious_class", 1, 0);
                else begin
                    chk("class_out", class_out, exp_cls.pop_front());
                    chk("class_lat", cyc - t0, 2571);
                end
            end
        end else busy_p = 1'b0;
    end

    task automatic clear_roms();
        for (int i = 0; i < 2560; i++) w_rom[i] = 0;
        for (int o = 0; o < 10; o++) b_rom[o] = 0;
        for (int f = 0; f < 256; f++) feat_m[f] = 0;
    endtask

    task automatic randomize_all();
        for (int i = 0; i < 2560; i++) w_rom[i] = byte'($urandom);
        for (int o = 0; o < 10; o++) b_rom[o] = int'($urandom_range(2000)) - 1000;
        for (int f = 0; f < 256; f++) feat_m[f] = byte'($urandom);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepts the last pixel.
    task automatic send_image();
        int acc [10];
        int best = 0;
        for (int o = 0; o < 10; o++) begin
            acc[o] = b_rom[o];
            for (int f = 0; f < 256; f++) acc[o] += int'(feat_m[f]) * int'(w_rom[o*256+f]);
            exp_lg.push_back(acc[o]);
            exp_ix.push_back(o);
            if (o == 0 || acc[o] > acc[best]) best = o;
        end
        exp_cls.push_back(best);
        for (int p = 0; p < 16; p++) begin
            valid_in = 1'b1;
            for (int c = 0; c < 16; c++) in_data[32*c +: 32] = 32'(int'(feat_m[c*16+p]));
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && exp_cls.size() != 0; i++) @(posedge clk);
        chk("drain", exp_cls.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int lb, cb;
        clear_roms();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_b_addr", b_addr, 0);
        chk("rst_logit", logit, 0);
        chk("rst_logit_idx", logit_idx, 0);
        chk("rst_class_out", class_out, 0);
        chk("rst_flags", {logit_valid, class_valid, busy, overrun}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // all ones, ties resolve to index 0
        for (int i = 0; i < 2560; i++) w_rom[i] = 1;
        for (int f = 0; f < 256; f++) feat_m[f] = 1;
        send_image();
        @(negedge clk);
        chk("busy_first", busy, 1);
        wait_idle();

        // most negative int8 squared, bias breaks the tie toward 9
        for (int i = 0; i < 2560; i++) w_rom[i] = -128;
        for (int o = 0; o < 10; o++) b_rom[o] = o;
        for (int f = 0; f < 256; f++) feat_m[f] = -128;
        send_image();
        wait_idle();

        // channel-major placement: ch1 pixel5 -> feature 21
        clear_roms();
        w_rom[3*256 + 21] = 2;
        feat_m[1*16 + 5] = 7;
        send_image();
        wait_idle();

        // back-to-back images, last pixel to first pixel exactly 2572 cycles
        clear_roms();
        for (int o = 0; o < 10; o++) w_rom[o*256 + o*20 + 3] = byte'(o + 1);
        feat_m[7*20 + 3] = 4;
        send_image();
        repeat (2571) @(posedge clk);
        #1;
        feat_m[7*20 + 3] = 0;
        feat_m[2*20 + 3] = 5;
        send_image();
        wait_idle();
        chk("no_overrun_b2b", n_ovr, 0);

        // stray pixel during neuron 4 is dropped and flagged
        randomize_all();
        send_image();
        repeat (257*4 + 30) @(posedge clk);
        #1;
        valid_in = 1'b1;
        in_data  = {16{$urandom}};
        @(negedge clk);
        chk("overrun_pulse", overrun, 1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        in_data  = '0;
        @(negedge clk);
        chk("overrun_clear", overrun, 0);
        @(posedge clk); #1;
        wait_idle();
        chk("overrun_count", n_ovr, 1);
        randomize_all();
        send_image();
        wait_idle();

        // reset during neuron 6 aborts without further pulses
        randomize_all();
        send_image();
        repeat (257*6 + 100) @(posedge clk);
        #1;
        exp_lg.delete();
        exp_ix.delete();
        exp_cls.delete();
        lb = n_logit;
        cb = n_class;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3000) @(posedge clk);
        #1;
        chk("no_logit_after_rst", n_logit, lb);
        chk("no_class_after_rst", n_class, cb);
        randomize_all();
        send_image();
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
